// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: signal bundle between the serial line/baud generator side
// and the uart_rx_frame receiver.
//
//   rx_tick    : one-clk enable pulse at OVERSAMPLE x baud rate
//   rxd        : raw asynchronous serial line, idle high
//   data       : last received byte, held until the next good frame
//   data_valid : one-clk pulse, data updated with a good stop bit
//   frame_err  : one-clk pulse, stop bit sampled low
//   parity_err : one-clk pulse, parity mismatch (parity build only)
//   busy       : receiver is not idle
//
// Modports: master = line/tick source plus consumer, slave = the receiver.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_tick;
    logic                 rxd;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rx_tick, rxd,
        input  data, data_valid, frame_err, parity_err, busy
    );

    modport slave (
        input  rx_tick, rxd,
        output data, data_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 (optionally 8E1) UART receive stage.
//
// The serial line is brought into the clk domain by a two-flop synchronizer
// and sampled using a 16x oversample enable (rx_tick). The start bit is
// confirmed at its middle, each data bit is sampled at its centre (LSB
// first), and the stop bit decides between a data_valid and a frame_err
// strobe. A stop bit sampled low parks the receiver in BREAK until the line
// returns high, so a held-low line never decodes as 0x00 frames.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   rx_if  : uart_rx_frame_if.slave (rx_tick, rxd in; data, data_valid,
//            frame_err, parity_err, busy out)
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit. Without it parity_err is tied 0.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int MID_SAMPLE = OVERSAMPLE / 2 - 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_frame_if.slave rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID_T  = TW'(MID_SAMPLE);
    localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_rxd_meta, r_rxd_s;
    logic [TW-1:0]        r_tcnt, w_tcnt_nxt;
    logic [BW-1:0]        r_bcnt, w_bcnt_nxt;
    logic [DATA_BITS-1:0] r_sr, w_sr_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_busy;
    logic                 w_centre;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 w_par_bad;
`endif

    assign w_centre = (r_tcnt == LAST_T);
`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    assign w_par_bad = (^r_sr) ^ r_par;
`endif

    // Two-flop synchronizer; idle-high reset value keeps the FSM out of
    // START while reset releases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values and the synchronizer stays two deep.
            r_rxd_meta <= rx_if.rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // State, counters, datapath and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            // NOTE: the shift register is reset too; it is tiny and a known
            // value keeps the parity check free of X on the first frame.
            r_sr    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_sr    <= w_sr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != IDLE);
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    // Next-state logic. Nothing moves on cycles without rx_tick.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bcnt_nxt  = r_bcnt;
        w_sr_nxt    = r_sr;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        if (rx_if.rx_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rxd_s) begin
                        w_tcnt_nxt  = '0;
                        w_state_nxt = START;
                    end
                end

                START: begin
                    if (r_tcnt == MID_T) begin
                        if (r_rxd_s) begin
                            // Line back high at mid start bit: glitch.
                            w_state_nxt = IDLE;
                        end else begin
                            w_tcnt_nxt  = '0;
                            w_bcnt_nxt  = '0;
                            w_state_nxt = DATA;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_centre) begin
                        // LSB arrives first, so shift in from the top.
                        w_sr_nxt   = {r_rxd_s, r_sr[DATA_BITS-1:1]};
                        w_tcnt_nxt = '0;
                        if (r_bcnt == LAST_B) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_bcnt_nxt = r_bcnt + 1'b1;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_centre) begin
                        w_par_nxt   = r_rxd_s;
                        w_tcnt_nxt  = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (w_centre) begin
                        w_tcnt_nxt = '0;
                        if (r_rxd_s) begin
                            // Back to IDLE at the stop centre so a start
                            // edge half a bit later is still caught.
                            w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (w_par_bad) begin
                                w_perr_nxt = 1'b1;
                            end else begin
                                w_data_nxt  = r_sr;
                                w_valid_nxt = 1'b1;
                            end
`else
                            w_data_nxt  = r_sr;
                            w_valid_nxt = 1'b1;
`endif
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = BREAK;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (r_rxd_s) begin
                        w_state_nxt = IDLE;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign rx_if.data       = r_data;
    assign rx_if.data_valid = r_valid;
    assign rx_if.frame_err  = r_ferr;
    assign rx_if.busy       = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = r_perr;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame. Each frame sent
// pushes its expected strobe (kind plus data value at that strobe) onto a
// queue; a monitor pops and compares whenever the receiver emits a strobe.
module tb_uart_rx_frame;
    logic clk;
    logic reset;

    uart_rx_frame_if #(.DATA_BITS(8)) u_if ();

    uart_rx_frame u_dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_VALID = 1, EV_FERR = 2, EV_PERR = 3} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         valid_stamp[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_valid_exp = 0;
    int         div = 4;
    int         phase = 0;
    int         tick_total = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge.
    task automatic step();
        @(negedge clk);
        phase = (phase + 1) % div;
        u_if.rx_tick = (phase == 0);
        if (u_if.rx_tick) tick_total++;
    endtask

    task automatic ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            step();
            if (u_if.rx_tick) k++;
        end
    endtask

    // Drives start, 8 data bits LSB first, parity (parity build), stop.
    // Leaves rxd at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        exp_t e;
        logic par_bad;
        par_bad = !par_ok;
        if (!stop) begin
            e.kind = EV_FERR;
            e.data = last_good;
        end else if (par_bad) begin
            e.kind = EV_PERR;
            e.data = last_good;
        end else begin
            e.kind = EV_VALID;
            e.data = b;
            last_good = b;
            n_valid_exp++;
        end
        exp_q.push_back(e);

        u_if.rxd = 1'b0;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            u_if.rxd = b[i];
            ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        u_if.rxd = (^b) ^ par_bad;
        ticks(16);
`endif
        u_if.rxd = stop;
        ticks(16);
    endtask

    // Monitor: sampled 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (u_if.data_valid || u_if.frame_err || u_if.parity_err) begin
                ev_kind_t kind;
                exp_t     e;
                if (u_if.data_valid)     kind = EV_VALID;
                else if (u_if.frame_err) kind = EV_FERR;
                else                     kind = EV_PERR;
                check("strobe_onehot",
                      32'(int'(u_if.data_valid) + int'(u_if.frame_err) + int'(u_if.parity_err)), 32'd1);
                check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'(kind), 32'(e.kind));
                    check("strobe_data", 32'(u_if.data), 32'(e.data));
                end
                if (kind == EV_VALID) begin
                    check("busy_at_valid", 32'(u_if.busy), 32'd0);
                    valid_stamp.push_back(tick_total);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b2b_base;
        u_if.rx_tick = 1'b0;
        u_if.rxd     = 1'b0;
        reset        = 1'b0;

        // Reset held with the line low and ticks running.
        repeat (40) step();
        check("rst_data",       32'(u_if.data),       32'd0);
        check("rst_data_valid", 32'(u_if.data_valid), 32'd0);
        check("rst_frame_err",  32'(u_if.frame_err),  32'd0);
        check("rst_parity_err", 32'(u_if.parity_err), 32'd0);
        check("rst_busy",       32'(u_if.busy),       32'd0);
        u_if.rxd = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        ticks(20);
        check("post_rst_busy", 32'(u_if.busy), 32'd0);
        check("post_rst_data", 32'(u_if.data), 32'd0);

        // Plain byte.
        send_frame(8'hA5, 1'b1, 1'b1);
        ticks(24);
        check("a5_idle_busy", 32'(u_if.busy), 32'd0);

        // Start-bit glitch: low for 4 ticks only.
        u_if.rxd = 1'b0;
        ticks(4);
        u_if.rxd = 1'b1;
        ticks(8);
        check("glitch_busy", 32'(u_if.busy), 32'd0);
        ticks(16);

        // Frame error, line held low, then a good byte.
        send_frame(8'h3C, 1'b0, 1'b1);
        ticks(40);
        check("break_busy", 32'(u_if.busy), 32'd1);
        check("break_data", 32'(u_if.data), 32'hA5);
        u_if.rxd = 1'b1;
        ticks(16);
        check("break_exit_busy", 32'(u_if.busy), 32'd0);
        send_frame(8'h55, 1'b1, 1'b1);
        ticks(24);

        // Back-to-back with zero idle gap.
        b2b_base = valid_stamp.size();
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        ticks(24);
        check("b2b_count", 32'(valid_stamp.size() - b2b_base), 32'd2);
        if (valid_stamp.size() - b2b_base == 2) begin
            check("b2b_spacing",
                  32'(valid_stamp[b2b_base + 1] - valid_stamp[b2b_base]),
                  32'd160);
        end

        // rx_tick held high continuously, then an odd divider.
        div = 1;
        send_frame(8'h96, 1'b1, 1'b1);
        ticks(24);
        div = 3;
        send_frame(8'h5A, 1'b1, 1'b1);
        ticks(24);
        div = 4;

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity 0 is wrong, parity 1 is right.
        send_frame(8'h07, 1'b1, 1'b0);
        ticks(24);
        check("perr_data_held", 32'(u_if.data), 32'h5A);
        send_frame(8'h07, 1'b1, 1'b1);
        ticks(24);
`endif

        // Reset in the middle of a frame: abandoned, no strobe.
        u_if.rxd = 1'b0;
        ticks(30);
        reset = 1'b0;
        repeat (3) step();
        check("midrst_busy", 32'(u_if.busy), 32'd0);
        check("midrst_data", 32'(u_if.data), 32'd0);
        u_if.rxd = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        last_good = 8'h00;
        ticks(20);
        check("midrst_idle", 32'(u_if.busy), 32'd0);

        send_frame(8'hC3, 1'b1, 1'b1);
        ticks(40);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("valid_total",   32'(valid_stamp.size()), 32'(n_valid_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
